// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: datapath width, ALU opcodes
// and the execute-stage control FSM encoding.
package cpu_pkg;

    localparam int unsigned WIDTH = 16;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_SLL   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_SRA   = 4'h7;
    localparam logic [3:0] ALU_SLT   = 4'h8;
    localparam logic [3:0] ALU_MUL   = 4'h9;
    localparam logic [3:0] ALU_PASSB = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ex_state_t;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute inputs and EX/MEM register outputs of the execute stage.
interface execute_stage_if #(
    parameter int unsigned WIDTH = 16
);
    logic             FlushE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             MemtoRegE;
    logic [2:0]       WriteRegE;
    logic [3:0]       AluControlE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;

    logic             StallE;
    logic             RegWriteM;
    logic             MemWriteM;
    logic             MemtoRegM;
    logic [2:0]       WriteRegM;
    logic [WIDTH-1:0] alu_resultM;
    logic             ZeroM;

    modport master (
        output FlushE, RegWriteE, MemWriteE, MemtoRegE, WriteRegE,
               AluControlE, SrcAE, SrcBE,
        input  StallE, RegWriteM, MemWriteM, MemtoRegM, WriteRegM,
               alu_resultM, ZeroM
    );

    modport slave (
        input  FlushE, RegWriteE, MemWriteE, MemtoRegE, WriteRegE,
               AluControlE, SrcAE, SrcBE,
        output StallE, RegWriteM, MemWriteM, MemtoRegM, WriteRegM,
               alu_resultM, ZeroM
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, keeps the low
// WIDTH bits of the unsigned product.
module seq_multiplier #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);
    import cpu_pkg::*;

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             w_last;

    assign w_last    = (r_count == CNT_W'(MUL_CYCLES - 1));
    // Asserted during the final iteration; the accumulator is complete after that edge.
    assign o_done    = r_busy && w_last;
    assign o_product = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_abort) begin
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU, MUL sequencing FSM and the EX/MEM pipeline
// register feeding the memory stage.
module execute_stage #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    execute_stage_if.slave  ex
);
    import cpu_pkg::*;

    ex_state_t        r_state;
    logic             r_regwrite;
    logic             r_memwrite;
    logic             r_memtoreg;
    logic [2:0]       r_writereg;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_is_mul;
    logic             w_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_result;
    logic             w_load;
    logic [3:0]       w_shamt;

    assign w_is_mul = (ex.AluControlE == ALU_MUL);
    assign w_start  = (r_state == IDLE) && w_is_mul && !ex.FlushE;
    assign w_shamt  = ex.SrcBE[3:0];

    seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst_n     (reset),
        .i_start   (w_start),
        .i_abort   (ex.FlushE),
        .i_a       (ex.SrcAE),
        .i_b       (ex.SrcBE),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_comb begin
        w_alu = ex.SrcBE;
        case (ex.AluControlE)
            ALU_ADD: w_alu = ex.SrcAE + ex.SrcBE;
            ALU_SUB: w_alu = ex.SrcAE - ex.SrcBE;
            ALU_AND: w_alu = ex.SrcAE & ex.SrcBE;
            ALU_OR:  w_alu = ex.SrcAE | ex.SrcBE;
            ALU_XOR: w_alu = ex.SrcAE ^ ex.SrcBE;
            ALU_SLL: w_alu = ex.SrcAE << w_shamt;
            ALU_SRL: w_alu = ex.SrcAE >> w_shamt;
            ALU_SRA: w_alu = $signed(ex.SrcAE) >>> w_shamt;
            ALU_SLT: w_alu = ($signed(ex.SrcAE) < $signed(ex.SrcBE)) ? WIDTH'(1) : '0;
            default: w_alu = ex.SrcBE;
        endcase
    end

    // In DONE the held MUL is still on the inputs; take the finished product instead.
    assign w_result = (r_state == DONE) ? w_product : w_alu;
    assign w_load   = !ex.FlushE &&
                      (((r_state == IDLE) && !w_is_mul) || (r_state == DONE));

    // Gated by reset so the stall reads 0 while reset is held, whatever is presented.
    assign ex.StallE = reset && !ex.FlushE &&
                       ((r_state == BUSY) || ((r_state == IDLE) && w_is_mul));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_writereg <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
        end else begin
            if (ex.FlushE) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE:    r_state <= w_is_mul ? BUSY : IDLE;
                    BUSY:    r_state <= w_mul_done ? DONE : BUSY;
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end

            if (w_load) begin
                r_regwrite <= ex.RegWriteE;
                r_memwrite <= ex.MemWriteE;
                r_memtoreg <= ex.MemtoRegE;
                r_writereg <= ex.WriteRegE;
                r_result   <= w_result;
                r_zero     <= (w_result == '0);
            end else begin
                r_regwrite <= 1'b0;
                r_memwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_writereg <= '0;
                r_result   <= '0;
                r_zero     <= 1'b0;
            end
        end
    end

    assign ex.RegWriteM   = r_regwrite;
    assign ex.MemWriteM   = r_memwrite;
    assign ex.MemtoRegM   = r_memtoreg;
    assign ex.WriteRegM   = r_writereg;
    assign ex.alu_resultM = r_result;
    assign ex.ZeroM       = r_zero;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a driver pushes per-cycle expectations from
// an instruction-level model, a monitor pops and compares on each falling edge.
module tb_execute_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_stage_if #(.WIDTH(16)) bus ();

    execute_stage #(
        .WIDTH      (16),
        .MUL_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    typedef struct packed {
        logic        stall;
        logic [22:0] m;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] m_now();
        return {bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.WriteRegM,
                bus.alu_resultM, bus.ZeroM};
    endfunction

    function automatic logic [22:0] mk_m(input logic rw, input logic mw, input logic m2r,
                                         input logic [2:0] wr, input logic [15:0] r);
        return {rw, mw, m2r, wr, r, (r == 16'h0000)};
    endfunction

    // Instruction-level ALU semantics
    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic [31:0]        prod;
        sa   = a;
        sb   = b;
        prod = {16'h0, a} * {16'h0, b};
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return a << b[3:0];
            4'h6:    return a >> b[3:0];
            4'h7:    return sa >>> b[3:0];
            4'h8:    return (sa < sb) ? 16'h0001 : 16'h0000;
            4'h9:    return prod[15:0];
            default: return b;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic rw, input logic mw, input logic m2r,
                         input logic [2:0] wr, input logic fl);
        bus.AluControlE = op;
        bus.SrcAE       = a;
        bus.SrcBE       = b;
        bus.RegWriteE   = rw;
        bus.MemWriteE   = mw;
        bus.MemtoRegE   = m2r;
        bus.WriteRegE   = wr;
        bus.FlushE      = fl;
    endtask

    task automatic push(input logic stall, input logic [22:0] m);
        exp_t e;
        e.stall = stall;
        e.m     = m;
        q.push_back(e);
    endtask

    // Entered just after a rising edge; returns just after the rising edge that
    // ends the instruction's last cycle in E.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic rw, input logic mw, input logic m2r,
                         input logic [2:0] wr, input int flush_at, input bit scramble);
        logic [15:0] da;
        logic [15:0] db;
        if (op != 4'h9) begin
            drive(op, a, b, rw, mw, m2r, wr, flush_at == 0);
            push(1'b0, (flush_at == 0) ? 23'h0 : mk_m(rw, mw, m2r, wr, ref_alu(op, a, b)));
            @(posedge clk); #1;
        end else begin
            for (int c = 0; c < 18; c++) begin
                da = a;
                db = b;
                if (c > 0 && scramble) begin
                    da = 16'($urandom);
                    db = 16'($urandom);
                end
                drive(op, da, db, rw, mw, m2r, wr, c == flush_at);
                if (c == flush_at)  push(1'b0, 23'h0);
                else if (c < 17)    push(1'b1, 23'h0);
                else                push(1'b0, mk_m(rw, mw, m2r, wr, ref_alu(op, a, b)));
                @(posedge clk); #1;
                if (c == flush_at) break;
            end
        end
    endtask

    // Monitor: StallE is checked in the cycle it belongs to, M one edge later.
    initial begin
        exp_t pend;
        bit   have_pend;
        exp_t e;
        have_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (have_pend) chk("m_reg", 32'(m_now()), 32'(pend.m));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("stall", 32'(bus.StallE), 32'(e.stall));
                    pend      = e;
                    have_pend = 1'b1;
                end else begin
                    have_pend = 1'b0;
                end
            end else begin
                have_pend = 1'b0;
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          fa;

        reset = 1'b0;
        drive(4'h0, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_m", 32'(m_now()), 32'h0);
        chk("reset_stall", 32'(bus.StallE), 32'h0);

        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        issue(4'h0, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 3'd0, -1, 1'b0);

        issue(4'h1, 16'd5, 16'd5, 1'b1, 1'b0, 1'b0, 3'd1, -1, 1'b0);
        issue(4'h0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 3'd2, -1, 1'b0);
        issue(4'h7, 16'h8000, 16'h0004, 1'b1, 1'b0, 1'b0, 3'd3, -1, 1'b0);
        issue(4'h8, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 3'd4, -1, 1'b0);

        issue(4'h9, 16'h0123, 16'h0010, 1'b1, 1'b0, 1'b0, 3'd5, -1, 1'b0);
        issue(4'h9, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b0, 3'd6, -1, 1'b1);
        issue(4'h9, 16'h1234, 16'h0005, 1'b1, 1'b0, 1'b0, 3'd7, 8, 1'b1);
        issue(4'h0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 3'd1, -1, 1'b0);

        issue(4'h0, 16'h0010, 16'h0004, 1'b0, 1'b1, 1'b0, 3'd0, -1, 1'b0);
        issue(4'h0, 16'h0010, 16'h0004, 1'b0, 1'b1, 1'b0, 3'd0, 0, 1'b0);

        // Back-to-back MULs, then flush landing in DONE
        issue(4'h9, 16'h0007, 16'h0009, 1'b1, 1'b0, 1'b0, 3'd2, -1, 1'b1);
        issue(4'h9, 16'hABCD, 16'h0101, 1'b1, 1'b0, 1'b1, 3'd3, -1, 1'b1);
        issue(4'h9, 16'h0003, 16'h0003, 1'b1, 1'b0, 1'b0, 3'd4, 17, 1'b1);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) op = 4'h9;
            a = 16'($urandom);
            b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            if (op == 4'h9) fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : -1;
            else            fa = ($urandom_range(0, 7) == 0) ? 0 : -1;
            issue(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), fa, 1'b1);
        end

        issue(4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, -1, 1'b0);
        @(negedge clk); #1;
        mon_en = 1'b0;

        // Reset in the middle of a MUL
        drive(4'h9, 16'h0005, 16'h0006, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midmul_reset_m", 32'(m_now()), 32'h0);
        chk("midmul_reset_stall", 32'(bus.StallE), 32'h0);
        drive(4'h0, 16'd2, 16'd2, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
        @(posedge clk); #1;
        chk("reset_hold_m", 32'(m_now()), 32'h0);
        reset  = 1'b1;
        mon_en = 1'b1;
        issue(4'h0, 16'd2, 16'd2, 1'b1, 1'b0, 1'b0, 3'd3, -1, 1'b0);
        issue(4'h9, 16'd7, 16'd9, 1'b1, 1'b0, 1'b0, 3'd2, -1, 1'b1);
        issue(4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, -1, 1'b0);
        @(negedge clk); #1;
        mon_en = 1'b0;

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
